mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of both requester ports and the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all data buses.
REQ-003 SHALL have port clock, input, 1, the only clock; all state updates on posedge clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have instruction-port inputs i_req (1) and i_addr (ADDR_W), and outputs i_gnt (1), i_rvalid (1) and i_rdata (DATA_W).
REQ-006 SHALL have data-port inputs d_req (1), d_we (1), d_lock (1), d_addr (ADDR_W) and d_wdata (DATA_W), and outputs d_gnt (1), d_rvalid (1) and d_rdata (DATA_W).
REQ-007 SHALL have memory-side outputs mem_read (1), mem_write (1), mem_addr (ADDR_W) and mem_wdata (DATA_W), and input mem_rdata (DATA_W); the memory samples on posedge and returns mem_rdata one cycle later.

Function
REQ-008 SHALL make grant combinational within the request cycle N: at most one of i_gnt/d_gnt high, and only for a port whose req is high.
REQ-009 SHALL drive mem_* from the granted port in cycle N: mem_read=~we, mem_write=we, addr/wdata passed through; all mem_* are 0 when there is no grant.
REQ-010 SHALL, for a granted read in cycle N, assert the owner's rvalid for exactly one cycle, N+1, with rdata=mem_rdata; the non-owner's rvalid is 0 and its rdata is 0.
REQ-011 SHALL never assert rvalid for writes (i port is read-only; a d write produces no rvalid).
REQ-012 SHALL sustain one grant per cycle; back-to-back grants pipeline, and the rvalid of N+1 coexists with the grant of N+1.
REQ-013 Requesters SHALL hold req/addr/data stable until gnt; the arbiter relies on this.
REQ-014 SHALL implement FSM states ARB (normal) and LOCK.
REQ-015 ARB->LOCK on a d grant with d_lock=1.
REQ-016 In LOCK, SHALL grant d only; i_gnt is forced to 0 even when d_req=0.
REQ-017 LOCK->ARB on the first d grant with d_lock=0 (that access is still granted), or on any cycle with d_req=0 and d_lock=0.
REQ-018 SHALL break a simultaneous i_req and d_req in ARB per REQ-024/REQ-025.
REQ-019 SHALL track the read owner in a register rd_own ∈ {NONE, I, D} that updates every cycle.

Reset
REQ-020 On reset high at posedge, state=ARB, rd_own=NONE, last-grant=I; i_rvalid=d_rvalid=0 and rdata=0 in the following cycle.
REQ-021 SHALL force all grants and mem_* to 0 while reset is high.
REQ-022 A read granted in the cycle before reset SHALL be discarded (no rvalid after reset).
REQ-023 Reset in LOCK SHALL return to ARB.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined, a tie SHALL go to the port not granted most recently; last-grant updates on every grant.
REQ-025 Without ARB_ROUND_ROBIN_EN, a tie SHALL always go to d (fixed priority); the last-grant register is not built.

Structure
REQ-026 SHALL place typedefs/constants in package mem_arb_pkg: owner enum (OWN_NONE, OWN_I, OWN_D), FSM state enum (ST_ARB, ST_LOCK).
REQ-027 SHALL use one sub-module, arb_pick2, for the combinational two-way pick (inputs: reqs, last-grant, force_d; output: one-hot grant).

Verification
Memory model preloaded with word k = 10*k+1, 1-cycle read latency.
REQ-028 i read addr 3 alone -> i_gnt in cycle 0; i_rvalid in cycle 1 with i_rdata=31; d_rvalid=0.
REQ-029 d write addr 5 data 0xAA, then d read addr 5 -> no rvalid for the write; read returns d_rdata=0xAA one cycle after its grant.
REQ-030 Both req every cycle, i addr 1, d addr 2, RR on -> grants alternate d,i,d,i (last=I after reset); rdata alternates 21, 11. RR off -> d granted continuously.
REQ-031 d read addr 4 with d_lock=1, d idle 2 cycles with lock held, i_req high -> i_gnt=0 throughout; d_lock drops -> i granted next cycle.
REQ-032 Reset asserted the cycle after an i read grant -> no i_rvalid; all outputs 0; first post-reset tie resolves per REQ-024/REQ-025.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Bit positions within the one-hot grant vector.
  localparam int unsigned GNT_I = 0;
  localparam int unsigned GNT_D = 1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way pick between the instruction and data requesters.
// ARB_ROUND_ROBIN_EN: ties go to the port not granted most recently; otherwise d wins.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic       i_req_i,
  input  logic       i_req_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       i_last_d,
`endif
  input  logic       i_force_d,
  output logic [1:0] o_gnt
);

  logic w_req_i;
  logic w_tie_to_i;

  always_comb begin
    w_req_i = i_req_i & ~i_force_d;
`ifdef ARB_ROUND_ROBIN_EN
    w_tie_to_i = i_last_d;
`else
    w_tie_to_i = 1'b0;
`endif
    o_gnt = '0;
    if (w_req_i && (!i_req_d || w_tie_to_i)) begin
      o_gnt[GNT_I] = 1'b1;
    end else if (i_req_d) begin
      o_gnt[GNT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-cycle-latency memory between an instruction and a data port.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; default is fixed priority to d.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t     r_state;
  state_t     w_state_nxt;
  owner_t     r_rd_own;
  owner_t     w_rd_own_nxt;
  logic [1:0] w_gnt;
  logic       w_req_i;
  logic       w_req_d;
  logic       w_i_rvalid;
  logic       w_d_rvalid;

  // Masking the requests keeps grants and mem_* quiet during reset.
  assign w_req_i = i_req & ~reset;
  assign w_req_d = d_req & ~reset;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (|w_gnt) begin
      r_last_d <= w_gnt[GNT_D];
    end
  end
`endif

  arb_pick2 u_pick (
    .i_req_i   (w_req_i),
    .i_req_d   (w_req_d),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_d  (r_last_d),
`endif
    .i_force_d (r_state == ST_LOCK),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_ARB;
      r_rd_own <= OWN_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_own <= w_rd_own_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_ARB: begin
        if (w_gnt[GNT_D] && d_lock) w_state_nxt = ST_LOCK;
      end
      ST_LOCK: begin
        if ((w_gnt[GNT_D] && !d_lock) || (!d_req && !d_lock)) w_state_nxt = ST_ARB;
      end
      default: w_state_nxt = ST_ARB;
    endcase

    w_rd_own_nxt = OWN_NONE;
    if (w_gnt[GNT_I]) begin
      w_rd_own_nxt = OWN_I;
    end else if (w_gnt[GNT_D] && !d_we) begin
      w_rd_own_nxt = OWN_D;
    end
  end

  // Gating rvalid with reset drops a read granted just before reset.
  always_comb begin
    i_gnt      = w_gnt[GNT_I];
    d_gnt      = w_gnt[GNT_D];
    mem_read   = w_gnt[GNT_I] | (w_gnt[GNT_D] & ~d_we);
    mem_write  = w_gnt[GNT_D] & d_we;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (w_gnt[GNT_I]) begin
      mem_addr = i_addr;
    end else if (w_gnt[GNT_D]) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
    w_i_rvalid = (r_rd_own == OWN_I) && !reset;
    w_d_rvalid = (r_rd_own == OWN_D) && !reset;
    i_rvalid   = w_i_rvalid;
    d_rvalid   = w_d_rvalid;
    i_rdata    = w_i_rvalid ? mem_rdata : '0;
    d_rdata    = w_d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus read-data scoreboard.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];
  logic          mem_init;

  typedef struct {
    bit            rst;
    bit            ireq;
    logic [AW-1:0] iaddr;
    bit            dreq;
    bit            dwe;
    bit            dlock;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    bit            ei;
    bit            ed;
  } vec_t;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_lock    (d_lock),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: writes on posedge, read data returned one cycle after the address.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int k = 0; k < 16; k++) mem[k] <= DW'(10 * k + 1);
      mem_rdata <= '0;
    end else begin
      if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  function automatic vec_t V(bit rst, bit ireq, logic [AW-1:0] ia, bit dreq, bit dwe,
                             bit dlock, logic [AW-1:0] da, logic [DW-1:0] dw, bit ei, bit ed);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = ia; v.dreq = dreq; v.dwe = dwe;
    v.dlock = dlock; v.daddr = da; v.dwdata = dw; v.ei = ei; v.ed = ed;
    return v;
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  task automatic apply(input vec_t v);
    exp_t          e;
    logic          exp_iv, exp_dv;
    logic [DW-1:0] exp_ir, exp_dr, exp_wd;
    logic [AW-1:0] exp_addr;
    reset = v.rst; i_req = v.ireq; i_addr = v.iaddr;
    d_req = v.dreq; d_we = v.dwe; d_lock = v.dlock; d_addr = v.daddr; d_wdata = v.dwdata;
    #3;
    if (v.rst) sb.delete();
    exp_iv = 1'b0; exp_dv = 1'b0; exp_ir = '0; exp_dr = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.is_d) begin exp_dv = 1'b1; exp_dr = e.data; end
      else begin exp_iv = 1'b1; exp_ir = e.data; end
    end
    chk("i_rvalid", 64'(i_rvalid), 64'(exp_iv));
    chk("i_rdata",  64'(i_rdata),  64'(exp_ir));
    chk("d_rvalid", 64'(d_rvalid), 64'(exp_dv));
    chk("d_rdata",  64'(d_rdata),  64'(exp_dr));
    chk("i_gnt",    64'(i_gnt),    64'(v.ei));
    chk("d_gnt",    64'(d_gnt),    64'(v.ed));
    exp_addr = v.ei ? v.iaddr : (v.ed ? v.daddr : '0);
    exp_wd   = v.ed ? v.dwdata : '0;
    chk("mem_read",  64'(mem_read),  64'(v.ei | (v.ed & ~v.dwe)));
    chk("mem_write", 64'(mem_write), 64'(v.ed & v.dwe));
    chk("mem_addr",  64'(mem_addr),  64'(exp_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(exp_wd));
    if (v.ei) sb.push_back('{1'b0, ref_mem[v.iaddr[3:0]], cyc + 1});
    if (v.ed && !v.dwe) sb.push_back('{1'b1, ref_mem[v.daddr[3:0]], cyc + 1});
    if (v.ed && v.dwe) ref_mem[v.daddr[3:0]] = v.dwdata;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    mem_init = 1'b1;
    for (int k = 0; k < 16; k++) ref_mem[k] = DW'(10 * k + 1);

    // reset with both requesting: no grants
    vecs.push_back(V(1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // i read addr 3 alone
    vecs.push_back(V(0, 1, 3, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // d write 5 <- AA, then read it back
    vecs.push_back(V(0, 0, 0, 1, 1, 0, 5, 32'hAA, 0, 1));
    vecs.push_back(V(0, 0, 0, 1, 0, 0, 5, 0, 0, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // reset then four ties
    vecs.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      bit odd;
      odd = (k % 2) == 1;
      vecs.push_back(V(0, 1, 1, 1, 0, 0, 2, 0, RR & odd, ~(RR & odd)));
    end
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // locked d read, d idles with lock held, i locked out
    vecs.push_back(V(0, 1, 1, 1, 0, 1, 4, 0, 0, 1));
    vecs.push_back(V(0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(V(0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(V(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(V(0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // lock exited by a d grant with lock low (a write)
    vecs.push_back(V(0, 0, 0, 1, 0, 1, 6, 0, 0, 1));
    vecs.push_back(V(0, 1, 7, 1, 1, 0, 7, 32'h55, 0, 1));
    vecs.push_back(V(0, 1, 7, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // i read, then reset the next cycle, then ties after reset
    vecs.push_back(V(0, 1, 3, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(V(1, 1, 1, 1, 0, 0, 2, 0, 0, 0));
    vecs.push_back(V(0, 1, 1, 1, 0, 0, 2, 0, 0, 1));
    vecs.push_back(V(0, 1, 1, 1, 0, 0, 2, 0, RR, ~RR));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[n]) begin
      apply(vecs[n]);
      if (n == 0) mem_init = 1'b0;
    end

    // reset while in LOCK must return to ARB
    apply(V(0, 0, 0, 1, 0, 1, 8, 0, 0, 1));
    apply(V(1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    apply(V(0, 1, 1, 0, 0, 1, 0, 0, 1, 0));
    apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain cyc=%0d actual=%0d expected=0", cyc, sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
